ahb_i2c_ctrl_fifo: RTL and testbench

AHB-Lite slave register front-end for the I2C bit/byte engine, replacing the single-byte register file with parametrised TX and RX FIFOs, a wider transfer counter, sticky write-1-to-clear status and a maskable interrupt. It sits between the AHB-Lite matrix and the I2C engine. It presents the engine with a valid/ready TX byte stream and accepts an RX byte push stream.

---
 rtl/ahb_i2c_pkg.sv | 43 ++++
 rtl/ahb_i2c_ctrl_fifo_if.sv | 27 ++
 rtl/i2c_sync_fifo.sv | 54 +++++
 rtl/ahb_i2c_ctrl_fifo.sv | 203 ++++++++++++++++++++
 tb/tb_ahb_i2c_ctrl_fifo.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_i2c_pkg.sv
// Shared constants for the AHB-Lite I2C control front-end.
// Register map, bit positions, reset constants and bus-phase bundle.
package ahb_i2c_pkg;

  localparam logic [4:0] OFS_CFG    = 5'h00;
  localparam logic [4:0] OFS_CTRL   = 5'h04;
  localparam logic [4:0] OFS_STATUS = 5'h08;
  localparam logic [4:0] OFS_DATA   = 5'h0c;
  localparam logic [4:0] OFS_IRQ_EN = 5'h10;
  localparam logic [4:0] OFS_LEVEL  = 5'h14;

  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;
  localparam int CTRL_ADACK = 2;
  localparam int CTRL_ACK   = 4;
  localparam int CTRL_MS    = 5;
  localparam int CTRL_AUTO  = 6;
  localparam int CTRL_EN    = 7;
  localparam int CTRL_TXFL  = 8;
  localparam int CTRL_RXFL  = 9;

  localparam int ST_RXNE  = 0;
  localparam int ST_STOPF = 1;
  localparam int ST_TXE   = 2;
  localparam int ST_TXF   = 3;
  localparam int ST_NACK  = 4;
  localparam int ST_SBF   = 5;
  localparam int ST_RXF   = 6;
  localparam int ST_RXOVF = 7;
  localparam int ST_TXOVF = 8;

  localparam logic [8:0] IRQ_MASK = 9'h195;

  localparam logic       CFG_WR_RST  = 1'b1;
  localparam logic [6:0] CFG_ADR_RST = 7'h5a;

  typedef struct packed {
    logic       vld;
    logic       wr;
    logic [4:0] addr;
  } ahb_ap_t;

endpackage

// File: rtl/ahb_i2c_ctrl_fifo_if.sv
// AHB-Lite slave port bundle for the I2C control front-end.
// The master modport is the bus side, the slave modport the register block.
interface ahb_i2c_ctrl_fifo_if;
  logic        HSEL;
  logic        HWRITE;
  logic        HREADY;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HWRITE, HREADY, HADDR,
    output HTRANS, HSIZE, HPROT, HWDATA,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HWRITE, HREADY, HADDR,
    input  HTRANS, HSIZE, HPROT, HWDATA,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/i2c_sync_fifo.sv
// Synchronous show-ahead FIFO with flush and fill level.
// Pointers carry one extra wrap bit so full and empty are distinct.
module i2c_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_pop;
  logic             do_push;

  assign level   = wptr - rptr;
  assign empty   = (wptr == rptr);
  assign full    = (level == FULL_LVL);
  assign do_pop  = pop & ~empty;
  // a pop frees the slot, so a full FIFO still takes the push
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rptr[AW-1:0]];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + ONE;
      if (do_pop)  rptr <= rptr + ONE;
    end
  end

  always_ff @(posedge HCLK) begin
    if (do_push & ~flush) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ahb_i2c_ctrl_fifo.sv
// AHB-Lite register front-end for the I2C engine.
// TX/RX byte FIFOs, sticky W1C status and a maskable registered irq.
module ahb_i2c_ctrl_fifo
  import ahb_i2c_pkg::*;
#(
  parameter int         TX_DEPTH = 4,
  parameter int         RX_DEPTH = 4,
  parameter int         CNT_W    = 8,
  parameter logic [6:0] ADR_RST  = CFG_ADR_RST
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  ahb_i2c_ctrl_fifo_if.slave bus,
  output logic             i2c_en,
  output logic             i2c_auto,
  output logic             i2c_ms,
  output logic             i2c_ack,
  output logic             i2c_autodetectack_en,
  output logic             i2c_stop,
  output logic             i2c_start,
  output logic             i2c_wr_r,
  output logic [6:0]       i2c_adr_r,
  output logic [CNT_W-1:0] cnt_set,
  input  logic             i2c_wr_slv,
  input  logic             stop_f,
  input  logic             sigbyte_finishf,
  input  logic             i2c_nackf_set,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  input  logic             tx_ready,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             irq
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);

  ahb_ap_t    ap;
  logic       wr, rd;
  logic       h_cfg, h_ctrl, h_st;
  logic       h_data, h_ien, h_lvl;
  logic       tx_full, tx_empty;
  logic       rx_full, rx_empty;
  logic       tx_push, tx_flush;
  logic       rx_pop, rx_flush;
  logic [7:0] rx_head;
  logic [TAW:0] tx_level;
  logic [RAW:0] rx_level;
  logic       nack, rx_ovf, tx_ovf;
  logic       w1c;
  logic       tx_ovf_set, rx_ovf_set;
  logic [8:0] irq_en;
  logic [8:0] irq_src;
  logic       unused_ok;

  assign bus.HREADYOUT = 1'b1;
  assign bus.HRESP     = 1'b0;
  assign unused_ok = ^{bus.HADDR[31:5], bus.HSIZE,
                       bus.HPROT, bus.HTRANS[0],
                       bus.HWDATA};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ap <= '0;
    end else begin
      ap.vld  <= bus.HSEL & bus.HTRANS[1] & bus.HREADY;
      ap.wr   <= bus.HWRITE;
      ap.addr <= bus.HADDR[4:0];
    end
  end

  assign wr     = ap.vld & ap.wr;
  assign rd     = ap.vld & ~ap.wr;
  assign h_cfg  = (ap.addr == OFS_CFG);
  assign h_ctrl = (ap.addr == OFS_CTRL);
  assign h_st   = (ap.addr == OFS_STATUS);
  assign h_data = (ap.addr == OFS_DATA);
  assign h_ien  = (ap.addr == OFS_IRQ_EN);
  assign h_lvl  = (ap.addr == OFS_LEVEL);

  assign tx_push  = wr & h_data;
  assign tx_flush = wr & h_ctrl & bus.HWDATA[CTRL_TXFL];
  assign rx_flush = wr & h_ctrl & bus.HWDATA[CTRL_RXFL];
  assign rx_pop   = rd & h_data & ~rx_empty;
  assign tx_valid = ~tx_empty;
  assign w1c      = wr & h_st;

  i2c_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .push    (tx_push),
    .pop     (tx_ready),
    .flush   (tx_flush),
    .din     (bus.HWDATA[7:0]),
    .head    (tx_data),
    .full    (tx_full),
    .empty   (tx_empty),
    .level   (tx_level)
  );

  i2c_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .push    (rx_valid),
    .pop     (rx_pop),
    .flush   (rx_flush),
    .din     (rx_data),
    .head    (rx_head),
    .full    (rx_full),
    .empty   (rx_empty),
    .level   (rx_level)
  );

  // overflow only when the byte is really lost
  assign tx_ovf_set = tx_push & tx_full
                    & ~(tx_ready & ~tx_empty)
                    & ~tx_flush;
  assign rx_ovf_set = rx_valid & rx_full
                    & ~rx_pop & ~rx_flush;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      i2c_wr_r  <= CFG_WR_RST;
      i2c_adr_r <= ADR_RST;
      cnt_set   <= '1;
    end else if (wr & h_cfg) begin
      {cnt_set, i2c_adr_r, i2c_wr_r} <=
        bus.HWDATA[CNT_W+7:0];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      i2c_start            <= 1'b0;
      i2c_stop             <= 1'b0;
      i2c_autodetectack_en <= 1'b0;
      i2c_ack              <= 1'b0;
      i2c_ms               <= 1'b0;
      i2c_auto             <= 1'b0;
      i2c_en               <= 1'b0;
    end else begin
      i2c_start <= wr & h_ctrl & bus.HWDATA[CTRL_START];
      if (wr & h_ctrl) begin
        i2c_stop             <= bus.HWDATA[CTRL_STOP];
        i2c_autodetectack_en <= bus.HWDATA[CTRL_ADACK];
        i2c_ack              <= bus.HWDATA[CTRL_ACK];
        i2c_ms               <= bus.HWDATA[CTRL_MS];
        i2c_auto             <= bus.HWDATA[CTRL_AUTO];
        i2c_en               <= bus.HWDATA[CTRL_EN];
      end else if (stop_f & ~i2c_auto) begin
        i2c_stop <= 1'b0;
      end
    end
  end

  // set term is OR-ed last so a coincident event beats the clear
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      nack   <= 1'b0;
      rx_ovf <= 1'b0;
      tx_ovf <= 1'b0;
      irq_en <= '0;
      irq    <= 1'b0;
    end else begin
      nack   <= i2c_nackf_set
              | (nack & ~(w1c & bus.HWDATA[ST_NACK]));
      rx_ovf <= rx_ovf_set
              | (rx_ovf & ~(w1c & bus.HWDATA[ST_RXOVF]));
      tx_ovf <= tx_ovf_set
              | (tx_ovf & ~(w1c & bus.HWDATA[ST_TXOVF]));
      if (wr & h_ien) irq_en <= bus.HWDATA[8:0] & IRQ_MASK;
      irq <= |(irq_en & irq_src);
    end
  end

  assign irq_src = {tx_ovf, rx_ovf, 2'b00, nack,
                    1'b0, tx_empty, 1'b0, ~rx_empty};

  always_comb begin
    bus.HRDATA = '0;
    if (rd) begin
      unique case (1'b1)
        h_cfg: bus.HRDATA = {{(24-CNT_W){1'b0}}, cnt_set,
                             i2c_adr_r,
                             i2c_ms ? i2c_wr_slv : i2c_wr_r};
        h_ctrl: bus.HRDATA = {24'b0, i2c_en, i2c_auto,
                              i2c_ms, i2c_ack, 1'b0,
                              i2c_autodetectack_en,
                              i2c_stop, 1'b0};
        h_st: bus.HRDATA = {23'b0, tx_ovf, rx_ovf, rx_full,
                            sigbyte_finishf, nack, tx_full,
                            tx_empty, stop_f, ~rx_empty};
        h_data: bus.HRDATA = rx_empty ? 32'b0
                                      : {24'b0, rx_head};
        h_ien: bus.HRDATA = {23'b0, irq_en};
        h_lvl: bus.HRDATA = {16'(rx_level), 16'(tx_level)};
        default: bus.HRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_i2c_ctrl_fifo.sv
// Self-checking bench for ahb_i2c_ctrl_fifo: register table,
// directed corner sequences and a queue-based random model.
module tb_ahb_i2c_ctrl_fifo;
  import ahb_i2c_pkg::*;

  localparam int TXD = 4;
  localparam int RXD = 4;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  ahb_i2c_ctrl_fifo_if bus();

  logic       i2c_en, i2c_auto, i2c_ms, i2c_ack;
  logic       i2c_autodetectack_en, i2c_stop, i2c_start;
  logic       i2c_wr_r;
  logic [6:0] i2c_adr_r;
  logic [7:0] cnt_set;
  logic       i2c_wr_slv, stop_f, sigbyte_finishf;
  logic       i2c_nackf_set;
  logic       tx_valid, tx_ready, rx_valid, irq;
  logic [7:0] tx_data, rx_data;

  ahb_i2c_ctrl_fifo #(
    .TX_DEPTH(TXD), .RX_DEPTH(RXD),
    .CNT_W(8), .ADR_RST(7'h5a)
  ) dut (
    .HCLK                 (HCLK),
    .HRESETn              (HRESETn),
    .bus                  (bus),
    .i2c_en               (i2c_en),
    .i2c_auto             (i2c_auto),
    .i2c_ms               (i2c_ms),
    .i2c_ack              (i2c_ack),
    .i2c_autodetectack_en (i2c_autodetectack_en),
    .i2c_stop             (i2c_stop),
    .i2c_start            (i2c_start),
    .i2c_wr_r             (i2c_wr_r),
    .i2c_adr_r            (i2c_adr_r),
    .cnt_set              (cnt_set),
    .i2c_wr_slv           (i2c_wr_slv),
    .stop_f               (stop_f),
    .sigbyte_finishf      (sigbyte_finishf),
    .i2c_nackf_set        (i2c_nackf_set),
    .tx_valid             (tx_valid),
    .tx_data              (tx_data),
    .tx_ready             (tx_ready),
    .rx_valid             (rx_valid),
    .rx_data              (rx_data),
    .irq                  (irq)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        w;
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] e;
  } vec_t;
  vec_t vt[$];

  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic       m_nack, m_rxo, m_txo;
  logic [8:0] m_en;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic ahb_wr(input logic [4:0] a, input logic [31:0] d);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10;
    bus.HWRITE = 1'b1; bus.HADDR = {27'b0, a};
    @(negedge HCLK);
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0; bus.HWDATA = d;
    @(negedge HCLK);
  endtask

  task automatic ahb_rd(input logic [4:0] a, output logic [31:0] d);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10;
    bus.HWRITE = 1'b0; bus.HADDR = {27'b0, a};
    @(negedge HCLK);
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    d = bus.HRDATA;
    @(negedge HCLK);
  endtask

  task automatic rdchk(input string nm, input logic [4:0] a,
                       input logic [31:0] exp);
    logic [31:0] d;
    ahb_rd(a, d);
    chk(nm, d, exp);
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    @(negedge HCLK);
    rx_valid = 1'b0;
  endtask

  task automatic add(input logic w, input logic [4:0] a,
                     input logic [31:0] d, input logic [31:0] e);
    vec_t v;
    v.w = w; v.a = a; v.d = d; v.e = e;
    vt.push_back(v);
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[ST_RXNE]  = rxq.size() != 0;
    s[ST_TXE]   = txq.size() == 0;
    s[ST_TXF]   = txq.size() == TXD;
    s[ST_NACK]  = m_nack;
    s[ST_RXF]   = rxq.size() == RXD;
    s[ST_RXOVF] = m_rxo;
    s[ST_TXOVF] = m_txo;
    return s;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, st;
    logic [7:0]  b;
    int          op;

    bus.HSEL = 0; bus.HWRITE = 0; bus.HREADY = 1;
    bus.HADDR = 0; bus.HTRANS = 0; bus.HSIZE = 3'b010;
    bus.HPROT = 0; bus.HWDATA = 0;
    i2c_wr_slv = 1; stop_f = 0; sigbyte_finishf = 0;
    i2c_nackf_set = 0; tx_ready = 0; rx_valid = 0;
    rx_data = 0;
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);

    chk("rst_hrdata", bus.HRDATA, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    chk("rst_adr", {25'b0, i2c_adr_r}, 32'h5a);
    chk("rst_cnt", {24'b0, cnt_set}, 32'hff);
    chk("rst_wr", {31'b0, i2c_wr_r}, 32'h1);

    // register table
    add(0, OFS_CFG,    0, 32'h0000ffb5);
    add(0, OFS_CTRL,   0, 32'h0);
    add(0, OFS_STATUS, 0, 32'h4);
    add(0, OFS_IRQ_EN, 0, 32'h0);
    add(0, OFS_LEVEL,  0, 32'h0);
    add(0, 5'h18,      0, 32'h0);
    add(1, OFS_CFG,    32'h00123456, 0);
    add(0, OFS_CFG,    0, 32'h00003456);
    add(1, OFS_CTRL,   32'h000003f6, 0);
    add(0, OFS_CTRL,   0, 32'h000000f6);
    add(0, OFS_CFG,    0, 32'h00003457);
    add(1, OFS_IRQ_EN, 32'hffffffff, 0);
    add(0, OFS_IRQ_EN, 0, 32'h00000195);
    add(1, OFS_IRQ_EN, 32'h0, 0);
    add(1, 5'h18,      32'hdeadbeef, 0);
    add(0, 5'h18,      0, 32'h0);
    add(0, OFS_CTRL,   0, 32'h000000f6);
    add(1, OFS_CTRL,   32'h0, 0);
    add(0, OFS_CTRL,   0, 32'h0);
    add(1, OFS_CFG,    32'h0000ffb5, 0);
    add(0, OFS_CFG,    0, 32'h0000ffb5);
    foreach (vt[i]) begin
      if (vt[i].w) ahb_wr(vt[i].a, vt[i].d);
      else rdchk($sformatf("tbl%0d", i), vt[i].a, vt[i].e);
    end

    ahb_wr(OFS_CFG, 32'h00009a4c);
    chk("cfg_adr", {25'b0, i2c_adr_r}, 32'h26);
    chk("cfg_wr", {31'b0, i2c_wr_r}, 32'h0);
    chk("cfg_cnt", {24'b0, cnt_set}, 32'h9a);
    ahb_wr(OFS_CFG, 32'h0000ffb5);

    // stop self-clears on stop_f when not in auto mode
    ahb_wr(OFS_CTRL, 32'h82);
    chk("stop_set", {31'b0, i2c_stop}, 32'h1);
    stop_f = 1'b1;
    @(negedge HCLK);
    stop_f = 1'b0;
    chk("stop_clr", {31'b0, i2c_stop}, 32'h0);

    ahb_wr(OFS_CTRL, 32'h81);
    chk("en", {31'b0, i2c_en}, 32'h1);
    chk("start_hi", {31'b0, i2c_start}, 32'h1);
    @(negedge HCLK);
    chk("start_lo", {31'b0, i2c_start}, 32'h0);
    rdchk("ctrl_rd", OFS_CTRL, 32'h80);

    // TX fill past full, then drain
    for (int i = 1; i <= 5; i++) ahb_wr(OFS_DATA, 32'(i * 8'h11));
    rdchk("tx_level", OFS_LEVEL, 32'h4);
    rdchk("tx_full_ovf", OFS_STATUS, 32'h108);
    for (int i = 1; i <= 4; i++) begin
      chk("tx_valid", {31'b0, tx_valid}, 32'h1);
      chk("tx_data", {24'b0, tx_data}, 32'(i * 8'h11));
      tx_ready = 1'b1;
      @(negedge HCLK);
      tx_ready = 1'b0;
    end
    chk("tx_drained", {31'b0, tx_valid}, 32'h0);
    ahb_wr(OFS_STATUS, 32'h100);
    rdchk("tx_ovf_w1c", OFS_STATUS, 32'h4);

    // RX single byte and empty read
    rx_push(8'ha5);
    rdchk("rx_a5", OFS_DATA, 32'ha5);
    ahb_rd(OFS_STATUS, d);
    chk("rx_ne_clr", {31'b0, d[ST_RXNE]}, 32'h0);
    rdchk("rx_empty_rd", OFS_DATA, 32'h0);

    // nack irq, set beats W1C
    ahb_wr(OFS_IRQ_EN, 32'h10);
    i2c_nackf_set = 1'b1;
    @(negedge HCLK);
    i2c_nackf_set = 1'b0;
    chk("irq_lag", {31'b0, irq}, 32'h0);
    @(negedge HCLK);
    chk("irq_set", {31'b0, irq}, 32'h1);
    bus.HSEL = 1; bus.HTRANS = 2'b10;
    bus.HWRITE = 1; bus.HADDR = {27'b0, OFS_STATUS};
    @(negedge HCLK);
    bus.HSEL = 0; bus.HTRANS = 0; bus.HWRITE = 0;
    bus.HWDATA = 32'h10; i2c_nackf_set = 1'b1;
    @(negedge HCLK);
    i2c_nackf_set = 1'b0;
    rdchk("nack_set_wins", OFS_STATUS, 32'h14);
    chk("irq_held", {31'b0, irq}, 32'h1);
    ahb_wr(OFS_STATUS, 32'h10);
    chk("irq_reg_lag", {31'b0, irq}, 32'h1);
    @(negedge HCLK);
    chk("irq_clr", {31'b0, irq}, 32'h0);
    ahb_wr(OFS_IRQ_EN, 32'h0);

    // RX full, push coincident with pop
    for (int i = 0; i < RXD; i++) rx_push(8'(8'hb0 + i));
    rdchk("rx_full_lvl", OFS_LEVEL, 32'h00040000);
    bus.HSEL = 1; bus.HTRANS = 2'b10;
    bus.HWRITE = 0; bus.HADDR = {27'b0, OFS_DATA};
    @(negedge HCLK);
    bus.HSEL = 0; bus.HTRANS = 0;
    rx_valid = 1'b1; rx_data = 8'hc4;
    chk("rx_pop_push", bus.HRDATA, 32'hb0);
    @(negedge HCLK);
    rx_valid = 1'b0;
    rdchk("rx_lvl_kept", OFS_LEVEL, 32'h00040000);
    rdchk("rx_no_ovf", OFS_STATUS, 32'h45);
    for (int i = 1; i < RXD; i++)
      rdchk("rx_order", OFS_DATA, 32'(8'hb0 + i));
    rdchk("rx_last", OFS_DATA, 32'hc4);

    // RX overflow, then flush coincident with push
    for (int i = 0; i <= RXD; i++) rx_push(8'(8'h60 + i));
    rdchk("rx_ovf", OFS_STATUS, 32'hc5);
    ahb_wr(OFS_STATUS, 32'h80);
    rdchk("rx_ovf_w1c", OFS_STATUS, 32'h45);
    bus.HSEL = 1; bus.HTRANS = 2'b10;
    bus.HWRITE = 1; bus.HADDR = {27'b0, OFS_CTRL};
    @(negedge HCLK);
    bus.HSEL = 0; bus.HTRANS = 0; bus.HWRITE = 0;
    bus.HWDATA = 32'h280; rx_valid = 1'b1; rx_data = 8'h99;
    @(negedge HCLK);
    rx_valid = 1'b0;
    rdchk("flush_lvl", OFS_LEVEL, 32'h0);
    rdchk("flush_no_ovf", OFS_STATUS, 32'h4);

    // asynchronous reset mid-cycle
    ahb_wr(OFS_DATA, 32'h77);
    ahb_wr(OFS_DATA, 32'h88);
    chk("pre_rst_valid", {31'b0, tx_valid}, 32'h1);
    #2 HRESETn = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, tx_valid}, 32'h0);
    chk("async_rst_en", {31'b0, i2c_en}, 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    rdchk("post_rst_cfg", OFS_CFG, 32'h0000ffb5);
    rdchk("post_rst_lvl", OFS_LEVEL, 32'h0);

    // random traffic against the queue model
    m_nack = 0; m_rxo = 0; m_txo = 0;
    m_en = 9'($urandom) & IRQ_MASK;
    ahb_wr(OFS_IRQ_EN, {23'b0, m_en});
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 7);
      b = 8'($urandom);
      case (op)
        0, 1: begin
          ahb_wr(OFS_DATA, {24'b0, b});
          if (txq.size() < TXD) txq.push_back(b);
          else m_txo = 1;
        end
        2: begin
          d = (rxq.size() != 0) ? {24'b0, rxq.pop_front()} : 0;
          rdchk("rnd_rx", OFS_DATA, d);
        end
        3: begin
          rx_push(b);
          if (rxq.size() < RXD) rxq.push_back(b);
          else m_rxo = 1;
        end
        4: begin
          chk("rnd_txv", {31'b0, tx_valid},
              {31'b0, txq.size() != 0});
          if (txq.size() != 0)
            chk("rnd_txd", {24'b0, tx_data}, {24'b0, txq[0]});
          tx_ready = 1'b1;
          @(negedge HCLK);
          tx_ready = 1'b0;
          if (txq.size() != 0) void'(txq.pop_front());
        end
        5: rdchk("rnd_lvl", OFS_LEVEL,
                 {16'(rxq.size()), 16'(txq.size())});
        6: begin
          st = exp_status();
          rdchk("rnd_status", OFS_STATUS, st);
          chk("rnd_irq", {31'b0, irq},
              {31'b0, |(st[8:0] & m_en)});
        end
        default: begin
          if (b[0]) begin
            i2c_nackf_set = 1'b1;
            @(negedge HCLK);
            i2c_nackf_set = 1'b0;
            m_nack = 1;
          end else begin
            d = $urandom;
            ahb_wr(OFS_STATUS, d);
            if (d[ST_NACK])  m_nack = 0;
            if (d[ST_RXOVF]) m_rxo = 0;
            if (d[ST_TXOVF]) m_txo = 0;
          end
        end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
